// File: rtl/cache_refill_ctrl.sv
// Miss handler (4-beat block refill into one 128-bit line) and write-through store port.
// Optional build macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN: wrap-around beat order + early word.
module cache_refill_ctrl #(
  parameter int unsigned BUS_WIDTH           = 32,
  parameter int unsigned BLOCK_SIZE          = 128,
  parameter int unsigned TAG_SIZE            = 3,
  parameter int unsigned INDEX_SIZE          = 5,
  parameter int unsigned ADDRESS_WIDTH_CACHE = 10
) (
  input  logic                           i_clk,
  input  logic                           i_aresetn,
  input  logic                           i_miss_req,
  input  logic [ADDRESS_WIDTH_CACHE-1:0] i_miss_addr,
  input  logic                           i_wr_req,
  input  logic [ADDRESS_WIDTH_CACHE-1:0] i_wr_addr,
  input  logic [BUS_WIDTH-1:0]           i_wr_data,
  output logic                           o_wr_ack,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDRESS_WIDTH_CACHE-1:0] o_mem_addr,
  output logic [BUS_WIDTH-1:0]           o_mem_wdata,
  input  logic                           i_mem_ack,
  input  logic [BUS_WIDTH-1:0]           i_mem_rdata,
  output logic                           o_fill_valid,
  output logic [INDEX_SIZE-1:0]          o_fill_index,
  output logic [TAG_SIZE-1:0]            o_fill_tag,
  output logic [BLOCK_SIZE-1:0]          o_fill_block,
  output logic                           o_stall,
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  output logic                           o_crit_valid,
  output logic [BUS_WIDTH-1:0]           o_crit_word,
`endif
  output logic                           o_busy
);

  localparam int unsigned OffW  = ADDRESS_WIDTH_CACHE - TAG_SIZE - INDEX_SIZE;
  localparam int unsigned LineW = ADDRESS_WIDTH_CACHE - OffW;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CritFirst = 1'b1;
`else
  localparam bit CritFirst = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWrite, StRefill, StFill} state_e;

  state_e                         state_q, state_d;
  logic [OffW-1:0]                cnt_q, cnt_d, start_q, start_d, cnt_nxt, first_off;
  logic [LineW-1:0]               line_q, line_d;
  logic [BLOCK_SIZE-1:0]          block_q, block_d;
  logic                           req_q, req_d, we_q, we_d;
  logic [ADDRESS_WIDTH_CACHE-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]           wdata_q, wdata_d;
  logic                           wr_ack_q, wr_ack_d;
  logic                           crit_valid_q, crit_valid_d;
  logic [BUS_WIDTH-1:0]           crit_word_q, crit_word_d;
  logic                           beat_ack;

  assign beat_ack  = req_q & i_mem_ack;
  assign cnt_nxt   = cnt_q + OffW'(1);
  assign first_off = i_miss_addr[OffW-1:0] & {OffW{CritFirst}};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    line_d       = line_q;
    block_d      = block_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_ack_d     = 1'b0;
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
    unique case (state_q)
      StIdle: begin
        // wr_ack_q high means i_wr_req still shows the store just committed
        if (i_wr_req && !wr_ack_q) begin
          state_d = StWrite;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = i_wr_addr;
          wdata_d = i_wr_data;
        end else if (i_miss_req) begin
          state_d = StRefill;
          line_d  = i_miss_addr[ADDRESS_WIDTH_CACHE-1:OffW];
          start_d = first_off;
          cnt_d   = first_off;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {i_miss_addr[ADDRESS_WIDTH_CACHE-1:OffW], first_off};
        end
      end
      StWrite: begin
        if (beat_ack) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          wr_ack_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StRefill: begin
        if (beat_ack) begin
          block_d[int'(cnt_q)*BUS_WIDTH +: BUS_WIDTH] = i_mem_rdata;
          if (cnt_q == start_q) begin
            crit_valid_d = 1'b1;
            crit_word_d  = i_mem_rdata;
          end
          // Beats wrap within the block; returning to the start offset means all words are in
          if (cnt_nxt == start_q) begin
            req_d   = 1'b0;
            state_d = StFill;
          end else begin
            cnt_d  = cnt_nxt;
            addr_d = {line_q, cnt_nxt};
          end
        end
      end
      StFill: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      start_q      <= '0;
      line_q       <= '0;
      block_q      <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_ack_q     <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      line_q       <= line_d;
      block_q      <= block_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_ack_q     <= wr_ack_d;
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign o_wr_ack     = wr_ack_q;
  assign o_mem_req    = req_q;
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_fill_valid = (state_q == StFill);
  assign o_fill_index = line_q[INDEX_SIZE-1:0];
  assign o_fill_tag   = line_q[LineW-1 -: TAG_SIZE];
  assign o_fill_block = block_q;
  assign o_busy       = (state_q != StIdle);
  // Gated by reset so the stall is low while the controller is held in reset
  assign o_stall      = i_aresetn & (i_miss_req | o_busy);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign o_crit_valid = crit_valid_q;
  assign o_crit_word  = crit_word_q;
`else
  logic unused_crit;
  assign unused_crit = crit_valid_q ^ (^crit_word_q);
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised bench for cache_refill_ctrl against a word-array memory and block-level reference.
module tb_cache_refill_ctrl;

  logic         i_clk = 1'b0;
  logic         i_aresetn;
  logic         i_miss_req;
  logic [9:0]   i_miss_addr;
  logic         i_wr_req;
  logic [9:0]   i_wr_addr;
  logic [31:0]  i_wr_data;
  logic         o_wr_ack;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [9:0]   o_mem_addr;
  logic [31:0]  o_mem_wdata;
  logic         i_mem_ack;
  logic [31:0]  i_mem_rdata;
  logic         o_fill_valid;
  logic [4:0]   o_fill_index;
  logic [2:0]   o_fill_tag;
  logic [127:0] o_fill_block;
  logic         o_stall;
  logic         o_busy;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic         o_crit_valid;
  logic [31:0]  o_crit_word;
`endif

  cache_refill_ctrl dut (
    .i_clk        (i_clk),
    .i_aresetn    (i_aresetn),
    .i_miss_req   (i_miss_req),
    .i_miss_addr  (i_miss_addr),
    .i_wr_req     (i_wr_req),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ack     (o_wr_ack),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_fill_valid (o_fill_valid),
    .o_fill_index (o_fill_index),
    .o_fill_tag   (o_fill_tag),
    .o_fill_block (o_fill_block),
    .o_stall      (o_stall),
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    .o_crit_valid (o_crit_valid),
    .o_crit_word  (o_crit_word),
`endif
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Physical memory: unwritten words read as the preload pattern
  logic [31:0] phys_mem [1024];
  bit          phys_vld [1024];
  logic [31:0] ref_mem  [1024];
  logic [10:0] op_log [$];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [127:0] last_blk;

  function automatic logic [31:0] phys_rd(input logic [9:0] a);
    return phys_vld[a] ? phys_mem[a] : 32'hA000_0000 + {22'd0, a};
  endfunction

  always @(negedge i_clk) begin
    if (o_mem_req && wcnt >= wait_cycles) begin
      i_mem_ack   <= 1'b1;
      i_mem_rdata <= o_mem_we ? $urandom : phys_rd(o_mem_addr);
      wcnt        <= 0;
    end else if (o_mem_req) begin
      i_mem_ack   <= 1'b0;
      i_mem_rdata <= $urandom;
      wcnt        <= wcnt + 1;
    end else begin
      i_mem_ack   <= 1'($urandom);   // stray acks must be ignored
      i_mem_rdata <= $urandom;
      wcnt        <= 0;
    end
  end

  always @(posedge i_clk) begin
    if (i_aresetn && o_mem_req && i_mem_ack) begin
      op_log.push_back({o_mem_we, o_mem_addr});
      if (o_mem_we) begin
        phys_mem[o_mem_addr] <= o_mem_wdata;
        phys_vld[o_mem_addr] <= 1'b1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [1:0] beat_off(input logic [9:0] a, input int k);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    return 2'(int'(a[1:0]) + k);
`else
    return 2'(k);
`endif
  endfunction

  function automatic logic [127:0] ref_block(input logic [9:0] a);
    logic [127:0] blk;
    for (int k = 0; k < 4; k++) blk[32*k +: 32] = ref_mem[{a[9:2], 2'(k)}];
    return blk;
  endfunction

  function automatic logic [255:0] all_outputs();
    logic [255:0] v;
    v = {72'd0, o_wr_ack, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_fill_valid,
         o_fill_index, o_fill_tag, o_fill_block, o_stall, o_busy};
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    v[255:223] = {o_crit_valid, o_crit_word};
`endif
    return v;
  endfunction

  // mode 0: store only; 1: miss only; 2: store+miss same cycle; 3: miss, store arrives at cycle 2
  task automatic run_txn(input int mode, input logic [9:0] maddr, input logic [9:0] waddr,
                         input logic [31:0] wdata, input int w, input bit drop);
    bit has_st, has_ms;
    int exp_fill, exp_wack, exp_crit, got_fill, got_wack, got_crit, n_crit, base;
    logic [127:0] exp_blk;
    logic [10:0] exp_ops [$];
    has_st = (mode != 1);
    has_ms = (mode != 0);
    exp_fill = -1;
    exp_wack = -1;
    exp_blk  = '0;
    case (mode)
      0: exp_wack = 2 + w;
      1: exp_fill = 5 + 4*w;
      2: begin exp_wack = 2 + w; exp_fill = 7 + 5*w; end
      default: begin exp_fill = 5 + 4*w; exp_wack = 8 + 5*w; end
    endcase
    exp_crit = has_ms ? exp_fill - 3 - 3*w : -1;
    if (has_st && mode != 3) begin
      ref_mem[waddr] = wdata;
      exp_ops.push_back({1'b1, waddr});
    end
    if (has_ms) begin
      exp_blk = ref_block(maddr);
      for (int k = 0; k < 4; k++) exp_ops.push_back({1'b0, maddr[9:2], beat_off(maddr, k)});
    end
    if (mode == 3) begin
      ref_mem[waddr] = wdata;
      exp_ops.push_back({1'b1, waddr});
    end

    base = op_log.size();
    wait_cycles = w;
    got_fill = -1; got_wack = -1; got_crit = -1; n_crit = 0;
    i_miss_addr = maddr;
    i_wr_addr   = waddr;
    i_wr_data   = wdata;
    i_wr_req    = has_st && mode != 3;
    i_miss_req  = has_ms;
    #1 check_val("stall_cycle0", o_stall, has_ms);
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (mode == 3 && n == 2) i_wr_req = 1'b1;
      if (drop && n == 3) i_miss_req = 1'b0;
      if (has_ms && got_fill < 0) check_val("stall_refill", o_stall, 1'b1);
      if (o_fill_valid) begin
        if (got_fill < 0) got_fill = n;
        check_val("fill_tag", o_fill_tag, maddr[9:7]);
        check_val("fill_index", o_fill_index, maddr[6:2]);
        check_val("fill_block", o_fill_block, exp_blk);
        last_blk = o_fill_block;
        i_miss_req = 1'b0;
      end
      if (o_wr_ack) begin
        if (got_wack < 0) got_wack = n;
        i_wr_req = 1'b0;
      end
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      if (o_crit_valid) begin
        n_crit++;
        got_crit = n;
        check_val("crit_word", o_crit_word, exp_blk[32*int'(maddr[1:0]) +: 32]);
      end
`endif
      if ((exp_fill < 0 || got_fill >= 0) && (exp_wack < 0 || got_wack >= 0)) break;
    end
    i_miss_req = 1'b0;
    i_wr_req   = 1'b0;
    tick();
    check_val("idle_after", {o_busy, o_fill_valid, o_wr_ack}, 3'b000);
    check_val("fill_cycle", got_fill, exp_fill);
    check_val("wr_ack_cycle", got_wack, exp_wack);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    check_val("crit_cycle", got_crit, exp_crit);
    check_val("crit_count", n_crit, has_ms ? 1 : 0);
`else
    if (got_crit != exp_crit && !has_ms) check_val("crit_unused", got_crit, -1);
`endif
    check_val("op_count", op_log.size() - base, exp_ops.size());
    for (int i = 0; i < exp_ops.size(); i++)
      if (base + i < op_log.size()) check_val("op_seq", op_log[base + i], exp_ops[i]);
  endtask

  initial begin
    int  mode, w, seen, bad;
    bit  drop;
    logic [9:0] ma, wa;

    for (int a = 0; a < 1024; a++) ref_mem[a] = 32'hA000_0000 + a;
    i_aresetn = 1'b0; i_miss_req = 1'b0; i_wr_req = 1'b0;
    i_miss_addr = '0; i_wr_addr = '0; i_wr_data = '0;

    // Reset held with random inputs
    for (int c = 0; c < 6; c++) begin
      i_miss_req  = 1'($urandom);
      i_wr_req    = 1'($urandom);
      i_miss_addr = 10'($urandom);
      i_wr_addr   = 10'($urandom);
      i_wr_data   = $urandom;
      tick();
      check_val("reset_outputs", all_outputs(), '0);
    end
    i_miss_req = 1'b0; i_wr_req = 1'b0;
    i_aresetn = 1'b1;
    tick();
    check_val("busy_after_reset", o_busy, 1'b0);

    // Zero-wait and 2-wait refills of 0x0A5
    run_txn(1, 10'h0A5, 10'h000, 32'h0, 0, 1'b0);
    check_val("blk_zero_wait", last_blk, 128'hA00000A7_A00000A6_A00000A5_A00000A4);
    run_txn(1, 10'h0A5, 10'h000, 32'h0, 2, 1'b0);
    check_val("blk_two_wait", last_blk, 128'hA00000A7_A00000A6_A00000A5_A00000A4);

    // Same-cycle store and miss: store goes first
    run_txn(2, 10'h0A5, 10'h0A6, 32'hDEADBEEF, 0, 1'b0);
    check_val("store_in_block", last_blk[95:64], 32'hDEADBEEF);

    // Reset after two beats
    wait_cycles = 0;
    seen = op_log.size();
    bad  = 0;
    i_miss_addr = 10'h0A5;
    i_miss_req  = 1'b1;
    for (int n = 0; n < 50 && op_log.size() - seen < 2; n++) begin
      tick();
      if (o_fill_valid) bad++;
    end
    check_val("beats_before_reset", op_log.size() - seen, 2);
    i_aresetn  = 1'b0;
    i_miss_req = 1'b0;
    #1 check_val("midop_reset_outputs", all_outputs(), '0);
    for (int n = 0; n < 3; n++) begin
      tick();
      if (o_fill_valid || o_wr_ack) bad++;
    end
    i_aresetn = 1'b1;
    tick();
    check_val("no_fill_after_reset", bad, 0);
    run_txn(1, 10'h0A5, 10'h000, 32'h0, 0, 1'b0);
    check_val("blk_after_reset", last_blk[31:0], ref_mem[10'h0A4]);

    // Randomised mix
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 3);
      w    = $urandom_range(0, 3);
      ma   = 10'($urandom);
      wa   = ($urandom_range(0, 1) == 1) ? {ma[9:2], 2'($urandom)} : 10'($urandom);
      drop = (mode == 1 || mode == 3) ? 1'($urandom) : 1'b0;
      run_txn(mode, ma, wa, $urandom, w, drop);
    end

    bad = 0;
    for (int a = 0; a < 1024; a++) if (phys_rd(10'(a)) !== ref_mem[a]) bad++;
    check_val("memory_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
